// File: rtl/add_rs_dispatch_pkg.sv
// Shared Tomasulo definitions for the add/sub reservation station: widths,
// opcodes, dispatcher state encodings and the per-entry record.
package tomasulo_defs;

  localparam int NUM_RS = 3;
  localparam int DW     = 8;
  localparam int TW     = 4;
  localparam int RW     = 3;
  localparam int RSW    = 3;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] DISPATCH = 2'b01;
  localparam logic [1:0] WAIT     = 2'b10;

  typedef struct packed {
    logic          busy;
    logic          disp;
    logic [3:0]    func;
    logic [TW-1:0] rd;
    logic [RW-1:0] rob;
    logic [TW-1:0] q1;
    logic [TW-1:0] q2;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
    logic          r1;
    logic          r2;
  } rs_entry_t;

  // A broadcast only fills an operand that is still waiting on that tag.
  function automatic logic tag_hit(input logic          bc_valid,
                                   input logic          rdy,
                                   input logic [TW-1:0] q,
                                   input logic [TW-1:0] tag);
    return bc_valid && !rdy && (q == tag);
  endfunction

endpackage

// File: rtl/add_rs_dispatch_snoop.sv
// One reservation-station entry: holds the issued op and captures missing
// operands from the result broadcast bus, including on the issue cycle itself.
module rs_entry_snoop
  import tomasulo_defs::*;
(
  input  logic          clk2,
  input  logic          rst,
  input  logic          i_alloc,
  input  logic          i_mark_disp,
  input  logic          i_free,
  input  logic [3:0]    i_func,
  input  logic [TW-1:0] i_rd,
  input  logic [RW-1:0] i_rob,
  input  logic [TW-1:0] i_q1,
  input  logic [TW-1:0] i_q2,
  input  logic [DW-1:0] i_v1,
  input  logic [DW-1:0] i_v2,
  input  logic          i_r1,
  input  logic          i_r2,
  input  logic          i_bc_valid,
  input  logic [TW-1:0] i_bc_tag,
  input  logic [DW-1:0] i_bc_data,
  output logic          o_busy,
  output logic          o_ready,
  output logic [3:0]    o_func,
  output logic [TW-1:0] o_rd,
  output logic [RW-1:0] o_rob,
  output logic [DW-1:0] o_v1,
  output logic [DW-1:0] o_v2
);

  rs_entry_t r_entry;
  rs_entry_t w_next;
  logic      w_iss_hit1;
  logic      w_iss_hit2;
  logic      w_snp_hit1;
  logic      w_snp_hit2;

  assign w_iss_hit1 = tag_hit(i_bc_valid, i_r1, i_q1, i_bc_tag);
  assign w_iss_hit2 = tag_hit(i_bc_valid, i_r2, i_q2, i_bc_tag);
  assign w_snp_hit1 = r_entry.busy && tag_hit(i_bc_valid, r_entry.r1, r_entry.q1, i_bc_tag);
  assign w_snp_hit2 = r_entry.busy && tag_hit(i_bc_valid, r_entry.r2, r_entry.q2, i_bc_tag);

  always_comb begin
    w_next = r_entry;
    if (i_alloc) begin
      w_next.busy = 1'b1;
      w_next.disp = 1'b0;
      w_next.func = i_func;
      w_next.rd   = i_rd;
      w_next.rob  = i_rob;
      w_next.q1   = i_q1;
      w_next.q2   = i_q2;
      w_next.r1   = i_r1 | w_iss_hit1;
      w_next.r2   = i_r2 | w_iss_hit2;
      w_next.v1   = w_iss_hit1 ? i_bc_data : i_v1;
      w_next.v2   = w_iss_hit2 ? i_bc_data : i_v2;
    end else begin
      if (i_free) begin
        w_next.busy = 1'b0;
        w_next.disp = 1'b0;
      end else if (i_mark_disp) begin
        w_next.disp = 1'b1;
      end else begin
        w_next.disp = r_entry.disp;
      end
      if (w_snp_hit1) begin
        w_next.r1 = 1'b1;
        w_next.v1 = i_bc_data;
      end else begin
        w_next.r1 = r_entry.r1;
      end
      if (w_snp_hit2) begin
        w_next.r2 = 1'b1;
        w_next.v2 = i_bc_data;
      end else begin
        w_next.r2 = r_entry.r2;
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      r_entry <= '0;
    end else begin
      r_entry <= w_next;
    end
  end

  assign o_busy  = r_entry.busy;
  assign o_ready = r_entry.busy && r_entry.r1 && r_entry.r2 && !r_entry.disp;
  assign o_func  = r_entry.func;
  assign o_rd    = r_entry.rd;
  assign o_rob   = r_entry.rob;
  assign o_v1    = r_entry.v1;
  assign o_v2    = r_entry.v2;

endmodule

// File: rtl/add_rs_dispatch.sv
// Add/sub reservation station and dispatcher: issues into free entries, picks the
// lowest ready entry, strobes ex_b for one cycle and waits for ex_done.
module add_rs_dispatch
  import tomasulo_defs::*;
(
  input  logic           clk2,
  input  logic           rst,
  input  logic           iss_valid,
  output logic           iss_ready,
  input  logic [3:0]     iss_func,
  input  logic [TW-1:0]  iss_rd,
  input  logic [RW-1:0]  iss_rob,
  input  logic [TW-1:0]  iss_q1,
  input  logic [TW-1:0]  iss_q2,
  input  logic [DW-1:0]  iss_v1,
  input  logic [DW-1:0]  iss_v2,
  input  logic           iss_r1,
  input  logic           iss_r2,
  input  logic           bc_valid,
  input  logic [TW-1:0]  bc_tag,
  input  logic [DW-1:0]  bc_data,
  output logic           ex_b,
  output logic [RSW-1:0] rs_index,
  output logic [DW-1:0]  rs1_data,
  output logic [DW-1:0]  rs2_data,
  output logic [3:0]     func,
  output logic [TW-1:0]  rd,
  output logic [RW-1:0]  rob_ind,
  input  logic           ex_done,
  output logic [1:0]     rs_count
);

  localparam logic [1:0] RS_FULL = 2'(NUM_RS);

  logic [NUM_RS-1:0] w_busy;
  logic [NUM_RS-1:0] w_ready;
  logic [NUM_RS-1:0] w_alloc;
  logic [NUM_RS-1:0] w_mark;
  logic [NUM_RS-1:0] w_free;
  logic [3:0]        w_func [NUM_RS];
  logic [TW-1:0]     w_rd   [NUM_RS];
  logic [RW-1:0]     w_rob  [NUM_RS];
  logic [DW-1:0]     w_v1   [NUM_RS];
  logic [DW-1:0]     w_v2   [NUM_RS];

  logic [RSW-1:0] w_free_idx;
  logic [RSW-1:0] w_rdy_idx;
  logic           w_any_rdy;
  logic           w_issue;
  logic           w_done;
  logic [3:0]     w_sel_func;
  logic [TW-1:0]  w_sel_rd;
  logic [RW-1:0]  w_sel_rob;
  logic [DW-1:0]  w_sel_v1;
  logic [DW-1:0]  w_sel_v2;

  logic [1:0]     r_state;
  logic [1:0]     r_count;
  logic [RSW-1:0] r_sel;
  logic           r_ex_b;
  logic [RSW-1:0] r_rs_index;
  logic [DW-1:0]  r_rs1_data;
  logic [DW-1:0]  r_rs2_data;
  logic [3:0]     r_func;
  logic [TW-1:0]  r_rd;
  logic [RW-1:0]  r_rob_ind;

  // iss_ready uses the pre-edge count, so a slot freed by ex_done is not reusable that cycle.
  assign iss_ready = (r_count < RS_FULL);
  assign w_issue   = iss_valid && iss_ready;
  assign w_done    = (r_state == WAIT) && ex_done;

  always_comb begin
    w_free_idx = '0;
    w_rdy_idx  = '0;
    w_any_rdy  = 1'b0;
    for (int k = NUM_RS - 1; k >= 0; k--) begin
      if (!w_busy[k]) begin
        w_free_idx = RSW'(k);
      end else begin
        w_free_idx = w_free_idx;
      end
      if (w_ready[k]) begin
        w_rdy_idx = RSW'(k);
        w_any_rdy = 1'b1;
      end else begin
        w_rdy_idx = w_rdy_idx;
      end
    end
  end

  always_comb begin
    w_sel_func = w_func[0];
    w_sel_rd   = w_rd[0];
    w_sel_rob  = w_rob[0];
    w_sel_v1   = w_v1[0];
    w_sel_v2   = w_v2[0];
    for (int k = 1; k < NUM_RS; k++) begin
      if (w_rdy_idx == RSW'(k)) begin
        w_sel_func = w_func[k];
        w_sel_rd   = w_rd[k];
        w_sel_rob  = w_rob[k];
        w_sel_v1   = w_v1[k];
        w_sel_v2   = w_v2[k];
      end else begin
        w_sel_func = w_sel_func;
      end
    end
  end

  for (genvar g = 0; g < NUM_RS; g++) begin : g_rs
    assign w_alloc[g] = w_issue && (w_free_idx == RSW'(g));
    assign w_mark[g]  = (r_state == IDLE) && w_any_rdy && (w_rdy_idx == RSW'(g));
    assign w_free[g]  = w_done && (r_sel == RSW'(g));

    rs_entry_snoop u_entry (
      .clk2        (clk2),
      .rst         (rst),
      .i_alloc     (w_alloc[g]),
      .i_mark_disp (w_mark[g]),
      .i_free      (w_free[g]),
      .i_func      (iss_func),
      .i_rd        (iss_rd),
      .i_rob       (iss_rob),
      .i_q1        (iss_q1),
      .i_q2        (iss_q2),
      .i_v1        (iss_v1),
      .i_v2        (iss_v2),
      .i_r1        (iss_r1),
      .i_r2        (iss_r2),
      .i_bc_valid  (bc_valid),
      .i_bc_tag    (bc_tag),
      .i_bc_data   (bc_data),
      .o_busy      (w_busy[g]),
      .o_ready     (w_ready[g]),
      .o_func      (w_func[g]),
      .o_rd        (w_rd[g]),
      .o_rob       (w_rob[g]),
      .o_v1        (w_v1[g]),
      .o_v2        (w_v2[g])
    );
  end

  // The output latch happens on the IDLE->DISPATCH edge so ex_b is high exactly while in DISPATCH.
  always_ff @(posedge clk2) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_ex_b     <= 1'b0;
      r_rs_index <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_func     <= '0;
      r_rd       <= '0;
      r_rob_ind  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_rdy) begin
            r_state    <= DISPATCH;
            r_sel      <= w_rdy_idx;
            r_ex_b     <= 1'b1;
            r_rs_index <= w_rdy_idx;
            r_rs1_data <= w_sel_v1;
            r_rs2_data <= w_sel_v2;
            r_func     <= w_sel_func;
            r_rd       <= w_sel_rd;
            r_rob_ind  <= w_sel_rob;
          end else begin
            r_ex_b <= 1'b0;
          end
        end
        DISPATCH: begin
          r_ex_b  <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_ex_b <= 1'b0;
          if (ex_done) begin
            r_state <= IDLE;
          end else begin
            r_state <= WAIT;
          end
        end
        default: begin
          r_ex_b  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      r_count <= 2'd0;
    end else begin
      case ({w_issue, w_done})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ex_b     = r_ex_b;
  assign rs_index = r_rs_index;
  assign rs1_data = r_rs1_data;
  assign rs2_data = r_rs2_data;
  assign func     = r_func;
  assign rd       = r_rd;
  assign rob_ind  = r_rob_ind;
  assign rs_count = r_count;

endmodule
